// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame blocks: parity modes, FSM encoding and
// the clocks-per-bit helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_t;

  function automatic int unsigned uart_div(input int unsigned sys_clk,
                                           input int unsigned baud);
    return sys_clk / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last clock of every DIV-clock bit while
// run is high; the count is held at zero whenever run is low.
module uart_baud_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_gen: DIV must be at least 2");
  end

  logic [CW-1:0] cnt;

  assign bit_tick = run && (cnt == LAST);

  // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-word holding buffer so that a word
// offered during a frame follows it on the line with no idle gap.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK   = 50_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_data,
  output logic                 out_en
);

  localparam int unsigned DIV = uart_div(SYS_CLK, BAUD);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: SYS_CLK / BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    return (PARITY == PARITY_ODD) ? ~^word : ^word;
  endfunction

  uart_state_t          state, state_n;
  logic [DATA_BITS-1:0] shifter, shifter_n, buf_data, buf_data_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic                 buf_full, buf_full_n, par_bit, par_bit_n;
  logic                 out_data_n, out_en_n;
  logic                 accept, bit_tick, load_in, load_buf;

  assign in_ready = ~buf_full;
  assign accept   = in_valid && in_ready;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state != IDLE),
    .bit_tick (bit_tick)
  );

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_n    = state;
    shifter_n  = shifter;
    bit_cnt_n  = bit_cnt;
    par_bit_n  = par_bit;
    buf_data_n = buf_data;
    buf_full_n = buf_full;
    load_in    = 1'b0;
    load_buf   = 1'b0;

    case (state)
      IDLE: begin
        if (buf_full)    load_buf = 1'b1;
        else if (accept) load_in  = 1'b1;
      end
      START: begin
        if (bit_tick) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_DATA) begin
            state_n   = (PARITY != PARITY_NONE) ? PAR : STOP;
            bit_cnt_n = '0;
          end else begin
            shifter_n = shifter >> 1;
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      PAR: begin
        if (bit_tick) begin
          state_n   = STOP;
          bit_cnt_n = '0;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt != LAST_STOP) bit_cnt_n = bit_cnt + 4'd1;
          else if (buf_full)        load_buf  = 1'b1;
          else if (accept)          load_in   = 1'b1;
          else                      state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A word arriving while the shifter is free bypasses the buffer entirely.
    if (load_in || load_buf) begin
      state_n   = START;
      shifter_n = load_buf ? buf_data : in_data;
      par_bit_n = parity_of(shifter_n);
      bit_cnt_n = '0;
    end
    if (load_buf) buf_full_n = 1'b0;
    if (accept && !load_in) begin
      buf_full_n = 1'b1;
      buf_data_n = in_data;
    end

    out_en_n = (state_n != IDLE);
    case (state_n)
      START:   out_data_n = 1'b0;
      DATA:    out_data_n = shifter_n[0];
      PAR:     out_data_n = par_bit_n;
      default: out_data_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shifter  <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      buf_data <= '0;
      buf_full <= 1'b0;
      out_data <= 1'b1;
      out_en   <= 1'b0;
    end else begin
      state    <= state_n;
      shifter  <= shifter_n;
      bit_cnt  <= bit_cnt_n;
      par_bit  <= par_bit_n;
      buf_data <= buf_data_n;
      buf_full <= buf_full_n;
      out_data <= out_data_n;
      out_en   <= out_en_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four configurations (8O1, 8E2, 7N1, 8O1 at DIV=2),
// hand-computed line frames queued at issue time and checked clock by clock by monitors.
module tb_uart_tx_frame;

  typedef logic [11:0] frame_t;  // line levels in time order, bit 0 = start bit
  typedef struct packed {
    logic   b2b;                 // must start on the clock right after the previous frame
    frame_t bits;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      rst_n_v;
  logic [3:0]      in_valid_v;
  logic [3:0][7:0] in_data_v;
  wire  [3:0]      in_ready_v, out_data_v, out_en_v;

  int   checks = 0;
  int   errors = 0;
  int   idle_bad [4] = '{default: 0};
  exp_t q0[$], q1[$], q2[$], q3[$];

  uart_tx_frame #(.SYS_CLK(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n_v[0]), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .out_data(out_data_v[0]), .out_en(out_en_v[0]));
  uart_tx_frame #(.SYS_CLK(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .rst_n(rst_n_v[1]), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .out_data(out_data_v[1]), .out_en(out_en_v[1]));
  uart_tx_frame #(.SYS_CLK(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7n1 (
    .clk(clk), .rst_n(rst_n_v[2]), .in_data(in_data_v[2][6:0]), .in_valid(in_valid_v[2]),
    .in_ready(in_ready_v[2]), .out_data(out_data_v[2]), .out_en(out_en_v[2]));
  uart_tx_frame #(.SYS_CLK(1_000_000), .BAUD(500_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_div2 (
    .clk(clk), .rst_n(rst_n_v[3]), .in_data(in_data_v[3]), .in_valid(in_valid_v[3]),
    .in_ready(in_ready_v[3]), .out_data(out_data_v[3]), .out_en(out_en_v[3]));

  function automatic int div_of(input int g);
    return (g == 3) ? 2 : 10;
  endfunction

  function automatic int nbits_of(input int g);
    case (g)
      1:       return 12;
      2:       return 9;
      default: return 11;
    endcase
  endfunction

  task automatic check(input bit ok, input string name, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, g, act, exp);
    end
  endtask

  task automatic push(input int g, input exp_t e);
    case (g)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic pop(input int g, output exp_t e, output bit got);
    got = 1'b0;
    e   = '0;
    case (g)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); got = 1'b1; end
    endcase
  endtask

  function automatic int qsize(input int g);
    case (g)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  // Monitor: compares every clock of a frame against the expected level for that bit.
  task automatic mon(input int g);
    bit     in_frame = 1'b0;
    bit     chain    = 1'b0;
    bit     got;
    int     k   = 0;
    int     bad = 0;
    exp_t   e;
    frame_t obs = '0;
    forever begin
      @(negedge clk);
      if (!rst_n_v[g]) begin
        in_frame = 1'b0;
        chain    = 1'b0;
        continue;
      end
      if (!in_frame && out_en_v[g]) begin
        pop(g, e, got);
        check(got, "frame_expected", g, 32'(got), 32'd1);
        if (!got) begin
          while (out_en_v[g] && rst_n_v[g]) @(negedge clk);
          chain = 1'b0;
          continue;
        end
        if (e.b2b) check(chain, "zero_gap", g, 32'(chain), 32'd1);
        in_frame = 1'b1;
        k   = 0;
        bad = 0;
        obs = '0;
      end
      chain = 1'b0;
      if (in_frame) begin
        if (out_data_v[g] !== e.bits[k / div_of(g)] || out_en_v[g] !== 1'b1) bad++;
        if (k % div_of(g) == div_of(g) / 2) obs[k / div_of(g)] = out_data_v[g];
        k++;
        if (k == nbits_of(g) * div_of(g)) begin
          check(bad == 0, "frame", g, 32'(obs), 32'(e.bits));
          in_frame = 1'b0;
          chain    = 1'b1;
        end
      end else if (out_data_v[g] !== 1'b1) begin
        idle_bad[g]++;
      end
    end
  endtask

  // Queues the expected frame, then offers the word until it is accepted.
  task automatic send(input int g, input logic [7:0] w, input frame_t f, input bit b2b);
    bit acc = 1'b0;
    bit rdy;
    push(g, '{b2b: b2b, bits: f});
    @(negedge clk);
    in_valid_v[g] = 1'b1;
    in_data_v[g]  = w;
    for (int t = 0; t < 2000; t++) begin
      rdy = in_ready_v[g];
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) check(acc, "accept_timeout", g, 32'(acc), 32'd1);
    #1;
    in_valid_v[g] = 1'b0;
    in_data_v[g]  = ~w;
  endtask

  task automatic wait_idle(input int g);
    int quiet = 0;
    for (int t = 0; t < 3000 && quiet < 3; t++) begin
      @(negedge clk);
      quiet = out_en_v[g] ? 0 : quiet + 1;
    end
    if (quiet < 3) check(1'b0, "idle_timeout", g, 32'(quiet), 32'd3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
      mon(3);
    join_none
  end

  initial begin
    int n;
    rst_n_v    = '0;
    in_valid_v = '0;
    in_data_v  = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check(out_data_v[g] === 1'b1, "reset_out_data", g, 32'(out_data_v[g]), 32'd1);
      check(out_en_v[g] === 1'b0, "reset_out_en", g, 32'(out_en_v[g]), 32'd0);
      check(in_ready_v[g] === 1'b1, "reset_in_ready", g, 32'(in_ready_v[g]), 32'd1);
    end
    rst_n_v = '1;

    // 8O1 single 0x55: four ones -> odd parity 1
    send(0, 8'h55, {1'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 1'b0);
    n = 0;
    repeat (115) begin
      @(negedge clk);
      if (!in_ready_v[0]) n++;
    end
    check(n == 0, "8o1_ready_low_clocks", 0, 32'(n), 32'd0);
    wait_idle(0);

    // 8E2 back-to-back 0x03, 0xA0 (even parity 0 both), then 0x01 (even parity 1)
    send(1, 8'h03, {2'b11, 1'b0, 8'h03, 1'b0}, 1'b0);
    send(1, 8'hA0, {2'b11, 1'b0, 8'hA0, 1'b0}, 1'b1);
    n = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready_v[1]) break;
      n++;
    end
    check(n == 119, "8e2_ready_low_clocks", 1, 32'(n), 32'd119);
    wait_idle(1);
    send(1, 8'h01, {2'b11, 1'b1, 8'h01, 1'b0}, 1'b0);
    wait_idle(1);

    // 7N1 0x7F: nine-bit frame, no parity slot
    send(2, 8'h7F, {3'b000, 1'b1, 7'h7F, 1'b0}, 1'b0);
    wait_idle(2);

    // DIV=2 8O1 back-to-back 0xAA, 0x55: parity 1 both
    send(3, 8'hAA, {1'b0, 1'b1, 1'b1, 8'hAA, 1'b0}, 1'b0);
    send(3, 8'h55, {1'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 1'b1);
    wait_idle(3);

    // Backpressure on 8O1: 0x07 (odd parity 0), 0x81 buffered, 0x11 held off
    send(0, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 1'b0);
    send(0, 8'h81, {1'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 1'b1);
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = 8'h11;
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (in_ready_v[0]) n++;
    end
    check(n == 0, "bp_ready_high_clocks", 0, 32'(n), 32'd0);
    send(0, 8'h11, {1'b0, 1'b1, 1'b1, 8'h11, 1'b0}, 1'b1);
    wait_idle(0);

    // Reset 37 clocks into a 0x00 frame, then a clean 0xFF frame
    send(0, 8'h00, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 1'b0);
    repeat (37) @(posedge clk);
    #2 rst_n_v[0] = 1'b0;
    #1;
    check(out_data_v[0] === 1'b1, "abort_out_data", 0, 32'(out_data_v[0]), 32'd1);
    check(out_en_v[0] === 1'b0, "abort_out_en", 0, 32'(out_en_v[0]), 32'd0);
    check(in_ready_v[0] === 1'b1, "abort_in_ready", 0, 32'(in_ready_v[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n_v[0] = 1'b1;
    send(0, 8'hFF, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0);
    wait_idle(0);

    repeat (5) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check(qsize(g) == 0, "frames_outstanding", g, 32'(qsize(g)), 32'd0);
      check(idle_bad[g] == 0, "idle_line_low", g, 32'(idle_bad[g]), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
